// File: rtl/usb_tx_arb_if.sv
// Byte-stream bundle between the two packet sources, the arbiter and the UTMI transmitter.
// master is the arbiter's view; slave is the view of the sources and transmitter around it.
interface usb_tx_arb_if;
    logic [7:0] a_data;
    logic       a_valid;
    logic       a_last;
    logic       a_ready;
    logic [7:0] b_data;
    logic       b_valid;
    logic       b_last;
    logic       b_ready;
    logic [7:0] data_out;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        input  a_data, a_valid, a_last,
        output a_ready,
        input  b_data, b_valid, b_last,
        output b_ready,
        output data_out, tx_valid,
        input  tx_ready
    );

    modport slave (
        output a_data, a_valid, a_last,
        input  a_ready,
        output b_data, b_valid, b_last,
        input  b_ready,
        input  data_out, tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/usb_tx_arb.sv
// Two-source USB transmit arbiter: port A (handshake/control) beats port B (data), no preemption,
// underrun drain and a programmable inter-packet gap before the next grant.
module usb_tx_arb #(
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           suspend_m,
    usb_tx_arb_if.master   bus,
    output logic           grant_a,
    output logic           grant_b,
    output logic           busy,
    output logic           err_underrun
);

    typedef enum logic [1:0] {StIdle, StActive, StDrain, StGap} state_e;

    localparam bit         HasGap  = (GAP_CYCLES > 0);
    localparam logic [3:0] GapLoad = HasGap ? 4'(GAP_CYCLES - 1) : 4'd0;

    state_e     state_q, state_d;
    logic       grant_a_q, grant_a_d;
    logic       grant_b_q, grant_b_d;
    logic       tx_valid_q, tx_valid_d;
    logic       err_q, err_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;

    logic src_valid;
    logic src_last;
    logic src_ready;

    assign src_valid = grant_a_q ? bus.a_valid : bus.b_valid;
    assign src_last  = grant_a_q ? bus.a_last  : bus.b_last;

    always_comb begin
        state_d   = state_q;
        grant_a_d = grant_a_q;
        grant_b_d = grant_b_q;
        gap_cnt_d = gap_cnt_q;
        err_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (suspend_m && bus.a_valid) begin
                    grant_a_d = 1'b1;
                    state_d   = StActive;
                end else if (suspend_m && bus.b_valid) begin
                    grant_b_d = 1'b1;
                    state_d   = StActive;
                end
            end
            StActive: begin
                // tx_ready low stalls everything; only a ready transmitter can see an underrun
                if (bus.tx_ready) begin
                    if (src_valid) begin
                        if (src_last) begin
                            if (HasGap) begin
                                state_d   = StGap;
                                gap_cnt_d = GapLoad;
                            end else begin
                                state_d   = StIdle;
                                grant_a_d = 1'b0;
                                grant_b_d = 1'b0;
                            end
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (src_valid && src_last) begin
                    if (HasGap) begin
                        state_d   = StGap;
                        gap_cnt_d = GapLoad;
                    end else begin
                        state_d   = StIdle;
                        grant_a_d = 1'b0;
                        grant_b_d = 1'b0;
                    end
                end
            end
            StGap: begin
                if (gap_cnt_q == 4'd0) begin
                    state_d   = StIdle;
                    grant_a_d = 1'b0;
                    grant_b_d = 1'b0;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d   = StIdle;
                grant_a_d = 1'b0;
                grant_b_d = 1'b0;
            end
        endcase

        tx_valid_d = (state_d == StActive);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            grant_a_q  <= 1'b0;
            grant_b_q  <= 1'b0;
            tx_valid_q <= 1'b0;
            err_q      <= 1'b0;
            gap_cnt_q  <= 4'd0;
        end else begin
            state_q    <= state_d;
            grant_a_q  <= grant_a_d;
            grant_b_q  <= grant_b_d;
            tx_valid_q <= tx_valid_d;
            err_q      <= err_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    // In DRAIN the source is emptied regardless of the transmitter
    assign src_ready = ((state_q == StActive) && bus.tx_ready) || (state_q == StDrain);

    assign bus.a_ready  = grant_a_q & src_ready;
    assign bus.b_ready  = grant_b_q & src_ready;
    assign bus.tx_valid = tx_valid_q;
    assign bus.data_out = grant_a_q ? bus.a_data : (grant_b_q ? bus.b_data : 8'h00);

    assign grant_a      = grant_a_q;
    assign grant_b      = grant_b_q;
    assign busy         = (state_q != StIdle);
    assign err_underrun = err_q;

endmodule
